// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 hex matrix keypad, debounces presses and
// releases, emits one key event per physical press and keeps a two-digit
// history (most recent / previous) for the dual seven-segment display.
module keypad_scanner #(
  parameter int SCAN_PERIOD    = 12000,  // clk cycles per scan tick
  parameter int DEBOUNCE_TICKS = 20      // matching ticks to accept press/release
) (
  input  logic       clk,
  input  logic       reset,      // asynchronous, active-low
  input  logic [3:0] rows,       // active-low, pulled up, asynchronous
  output logic [3:0] cols,       // active-low, one column driven at a time
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  localparam int TW = (SCAN_PERIOD > 2) ? $clog2(SCAN_PERIOD) : 1;
  localparam int DW = (DEBOUNCE_TICKS > 2) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_PERIOD - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [DW-1:0] DEB_ONE   = DW'(1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t          state_reg;
  logic [TW-1:0]   tick_cnt_reg;
  logic [DW-1:0]   deb_cnt_reg;
  logic [1:0]      col_idx_reg;
  logic [1:0]      lrow_reg;
  logic [3:0]      rows_meta_reg;
  logic [3:0]      rs_reg;
  logic            tick;
  logic            any_low;
  logic [1:0]      first_low;
  logic            row_high;

  // Two-flop synchronizer per row line; idle (pulled-up) value out of reset.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row_sync
      // Bring each asynchronous row line into the clk domain.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rows_meta_reg[gi] <= 1'b1;
          rs_reg[gi]        <= 1'b1;
        end else begin
          rows_meta_reg[gi] <= rows[gi];
          rs_reg[gi]        <= rows_meta_reg[gi];
        end
      end
    end
  endgenerate

  // Free-running scan timer; it never stops, whatever the FSM is doing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_reg <= '0;
    end else if (tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + TW'(1);
    end
  end

  assign tick = (tick_cnt_reg == TICK_LAST);

  // Lowest-index low row wins when several rows in a column are pressed.
  always_comb begin
    first_low = 2'd3;
    if (!rs_reg[2]) first_low = 2'd2;
    if (!rs_reg[1]) first_low = 2'd1;
    if (!rs_reg[0]) first_low = 2'd0;
  end

  assign any_low  = ~&rs_reg;
  assign row_high = rs_reg[lrow_reg];
  assign cols     = ~(4'b0001 << col_idx_reg);

  // Hex legend of the matrix, indexed by latched row and frozen column.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  // Scan / debounce / hold / release FSM with registered outputs; all
  // decisions are taken on scan ticks only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= SCAN;
      deb_cnt_reg <= '0;
      col_idx_reg <= 2'd0;
      lrow_reg    <= 2'd0;
      key_code    <= 4'h0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
      digit_new   <= 4'h0;
      digit_old   <= 4'h0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (state_reg)
          SCAN: begin
            if (any_low) begin
              lrow_reg    <= first_low;
              deb_cnt_reg <= DEB_ONE;
              state_reg   <= DEBOUNCE;
            end else begin
              col_idx_reg <= col_idx_reg + 2'd1;
            end
          end
          DEBOUNCE: begin
            if (row_high) begin
              state_reg   <= SCAN;
              col_idx_reg <= col_idx_reg + 2'd1;
            end else if (deb_cnt_reg == DEB_LAST) begin
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              key_code  <= key_map(lrow_reg, col_idx_reg);
              digit_new <= key_map(lrow_reg, col_idx_reg);
              digit_old <= digit_new;
              state_reg <= HELD;
            end else begin
              deb_cnt_reg <= deb_cnt_reg + DW'(1);
            end
          end
          HELD: begin
            if (row_high) begin
              deb_cnt_reg <= DEB_ONE;
              state_reg   <= RELEASE;
            end
          end
          default: begin  // RELEASE
            if (!row_high) begin
              state_reg <= HELD;
            end else if (deb_cnt_reg == DEB_LAST) begin
              key_held    <= 1'b0;
              state_reg   <= SCAN;
              col_idx_reg <= col_idx_reg + 2'd1;
            end else begin
              deb_cnt_reg <= deb_cnt_reg + DW'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: directed scenarios with cycle-exact
// expectations derived from the tick grid, then random single-key presses
// checked against a digit-history model.
module tb_keypad_scanner;

  localparam int P = 4;  // SCAN_PERIOD
  localparam int D = 3;  // DEBOUNCE_TICKS

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [3:0] digit_new;
  logic [3:0] digit_old;

  keypad_scanner #(.SCAN_PERIOD(P), .DEBOUNCE_TICKS(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .digit_new (digit_new),
    .digit_old (digit_old)
  );

  always #5 clk = ~clk;

  // Physical keypad: one key (pr, pc) may be pressed; its row reads low
  // only while its column is driven.
  logic       pressed = 1'b0;
  logic [1:0] pr = 2'd0;
  logic [1:0] pc = 2'd0;
  always_comb begin
    rows = 4'hF;
    if (pressed && (cols[pc] == 1'b0)) rows[pr] = 1'b0;
  end

  int checks = 0;
  int failures = 0;
  int ecount = 0;   // clock edges since the last reset release
  int vcount = 0;   // key_valid pulses seen
  int vedge = -1;   // edge of the last key_valid pulse
  int cols_bad = 0;
  logic [3:0] keymap [16];
  logic [3:0] hist [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (edge %0d)", tag, got, exp, ecount);
    end
  endtask

  function automatic logic [3:0] exp_cols(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    ecount++;
    if (key_valid) begin
      vcount++;
      vedge = ecount;
    end
  endtask

  task automatic run_to(input int n);
    while (ecount < n) step();
  endtask

  task automatic press(input int r, input int c);
    pr = 2'(r);
    pc = 2'(c);
    pressed = 1'b1;
  endtask

  initial begin
    int r, c, hold, gap;
    keymap[0]  = 4'h1; keymap[1]  = 4'h2; keymap[2]  = 4'h3; keymap[3]  = 4'hA;
    keymap[4]  = 4'h4; keymap[5]  = 4'h5; keymap[6]  = 4'h6; keymap[7]  = 4'hB;
    keymap[8]  = 4'h7; keymap[9]  = 4'h8; keymap[10] = 4'h9; keymap[11] = 4'hC;
    keymap[12] = 4'hE; keymap[13] = 4'h0; keymap[14] = 4'hF; keymap[15] = 4'hD;

    // 1. Reset
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    ecount = 0;
    vcount = 0;
    #1;
    check("rst_cols", 32'(cols), 32'(4'b1110));
    check("rst_valid", 32'(key_valid), 0);
    check("rst_held", 32'(key_held), 0);
    check("rst_dnew", 32'(digit_new), 0);
    check("rst_dold", 32'(digit_old), 0);
    check("rst_code", 32'(key_code), 0);

    // 2. Idle: one column step per tick, ticks every P edges
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_cols", 32'(cols), 32'(exp_cols((ecount / P) % 4)));
    end
    check("idle_no_event", vcount, 0);

    // 3. Press '5' (row1, col1); column 1 is active from edge 20
    press(1, 1);
    cols_bad = 0;
    while (ecount < 60) begin
      step();
      if (cols != exp_cols(1)) cols_bad++;
    end
    check("p5_events", vcount, 1);
    check("p5_latency", vedge, 24 + (D - 1) * P);
    check("p5_code", 32'(key_code), 5);
    check("p5_dnew", 32'(digit_new), 5);
    check("p5_dold", 32'(digit_old), 0);
    check("p5_held", 32'(key_held), 1);
    check("p5_cols_frozen", cols_bad, 0);

    // 4. Release '5', then press 'A' (row0, col3)
    pressed = 1'b0;
    run_to(71);
    check("rel5_pending", 32'(key_held), 1);
    run_to(72);
    check("rel5_held", 32'(key_held), 0);
    check("rel5_resume_col2", 32'(cols), 32'(exp_cols(2)));
    press(0, 3);
    vcount = 0;
    run_to(100);
    check("pA_events", vcount, 1);
    check("pA_latency", vedge, 80 + (D - 1) * P);
    check("pA_code", 32'(key_code), 32'hA);
    check("pA_dnew", 32'(digit_new), 32'hA);
    check("pA_dold", 32'(digit_old), 5);
    pressed = 1'b0;
    run_to(112);
    check("relA_held", 32'(key_held), 0);
    check("relA_cols", 32'(cols), 32'(exp_cols(0)));

    // 5a. Press bounce: row low for a single tick only
    run_to(116);
    check("bnc_col1", 32'(cols), 32'(exp_cols(1)));
    press(1, 1);
    vcount = 0;
    run_to(120);
    pressed = 1'b0;
    run_to(124);
    check("bnc_resume_col2", 32'(cols), 32'(exp_cols(2)));
    run_to(130);
    check("bnc_no_event", vcount, 0);

    // 5b. Release glitch: high for one tick while held, then low again
    press(1, 1);
    run_to(149);
    check("gl_events", vcount, 1);
    check("gl_latency", vedge, 140 + (D - 1) * P);
    check("gl_dnew", 32'(digit_new), 5);
    check("gl_dold", 32'(digit_old), 32'hA);
    pressed = 1'b0;
    run_to(153);
    press(1, 1);
    vcount = 0;
    cols_bad = 0;
    while (ecount < 175) begin
      step();
      if (cols != exp_cols(1) || key_held != 1'b1) cols_bad++;
    end
    check("gl_no_event", vcount, 0);
    check("gl_still_held", 32'(key_held), 1);
    check("gl_hold_stable", cols_bad, 0);

    // 6. Reset while '5' is held
    #2;
    reset = 1'b0;
    #1;
    check("rstH_cols", 32'(cols), 32'(4'b1110));
    check("rstH_held", 32'(key_held), 0);
    check("rstH_dnew", 32'(digit_new), 0);
    check("rstH_dold", 32'(digit_old), 0);
    check("rstH_code", 32'(key_code), 0);
    @(negedge clk);
    reset = 1'b1;
    ecount = 0;
    vcount = 0;
    run_to(20);
    check("rstH_events", vcount, 1);
    check("rstH_latency", vedge, 8 + (D - 1) * P);
    check("rstH_redet_dnew", 32'(digit_new), 5);
    check("rstH_redet_dold", 32'(digit_old), 0);
    pressed = 1'b0;
    run_to(40);
    check("rstH_released", 32'(key_held), 0);

    // Random single-key presses against a digit-history model
    hist.delete();
    hist.push_back(4'h0);
    hist.push_back(4'h5);
    for (int i = 0; i < 12; i++) begin
      r = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 3));
      hold = (4 + D + 2) * P + int'($urandom_range(0, 7));
      gap  = (D + 2) * P + int'($urandom_range(0, 7));
      hist.push_back(keymap[r * 4 + c]);
      vcount = 0;
      press(r, c);
      repeat (hold) step();
      check("rnd_events", vcount, 1);
      check("rnd_code", 32'(key_code), 32'(hist[$]));
      check("rnd_dnew", 32'(digit_new), 32'(hist[$]));
      check("rnd_dold", 32'(digit_old), 32'(hist[$-1]));
      check("rnd_held", 32'(key_held), 1);
      pressed = 1'b0;
      repeat (gap) step();
      check("rnd_released", 32'(key_held), 0);
      check("rnd_no_release_event", vcount, 1);
      $display("press %0d: key=%0h held=%0d cycles, events=%0d", i, hist[$], hold, vcount);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 hex matrix keypad and debounces presses, so keyed digits replace the DIP-switch inputs to the dual seven-segment display path.
- Drives the keypad columns and reads the rows.
- Emits one registered key event per physical press.
- Keeps a two-digit history, most recent and previous, that feeds the display multiplexer's s0/s1 inputs directly.

Parameters:
- SCAN_PERIOD, 12000: clk cycles per scan tick; 1 ms at 12 MHz. Legal range >= 2.
- DEBOUNCE_TICKS, 20: consecutive matching ticks required to accept a press or a release. Legal range >= 2.

Ports:
- clk  input  1  system clock, 12 MHz.
- reset  input  1  asynchronous, active-low reset.
- rows  input  4  keypad rows; active-low, externally pulled up, asynchronous to clk.
- cols  output  4  keypad column drive; active-low, exactly one bit low at any time.
- key_code  output  4  hex value of the last accepted key.
- key_valid  output  1  one-cycle pulse when a press is accepted.
- key_held  output  1  high from acceptance until the release is accepted.
- digit_new  output  4  most recently accepted key; connects to display s0.
- digit_old  output  4  previously accepted key; connects to display s1.

Behaviour:
- Reset (reset=0, asynchronous):
  - cols=4'b1110 (column 0 active); state=SCAN; all counters 0.
  - key_code, digit_new, digit_old = 0; key_valid=0; key_held=0.
- Synchronizer: rows passes through a 2-flop synchronizer (reset value 4'b1111). All decisions use the synchronized value rs.
- Tick timer:
  - Counts 0..SCAN_PERIOD-1 and wraps.
  - tick=1 for the single cycle in which count==SCAN_PERIOD-1.
  - Runs in every state. All sampling happens only on tick.
- Column drive: cols = ~(4'b0001 << col_idx). col_idx changes only on the SCAN transitions listed below.
- Key map, row r / column c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- FSM states SCAN, DEBOUNCE, HELD, RELEASE:
  - SCAN, on tick:
    - If any rs bit is 0: latch col_idx and the lowest-index low row as lrow; deb_cnt=1; go to DEBOUNCE.
    - Otherwise col_idx = col_idx+1 (mod 4; 3 wraps to 0).
  - DEBOUNCE (column frozen), on tick:
    - If rs[lrow]==0 and deb_cnt==DEBOUNCE_TICKS-1: accept the press and go to HELD.
    - If rs[lrow]==0 otherwise: deb_cnt+1.
    - If rs[lrow]==1: go to SCAN, col_idx+1, no event.
  - Accept, all registered on the same edge:
    - key_valid=1 for exactly one cycle.
    - key_code = map(lrow, col_idx).
    - digit_old = digit_new; digit_new = map(lrow, col_idx).
    - key_held=1.
  - HELD, on tick: if rs[lrow]==1, deb_cnt=1 and go to RELEASE. Other rows in the frozen column are ignored.
  - RELEASE, on tick:
    - If rs[lrow]==0: return to HELD (a bounce during release).
    - Else if deb_cnt==DEBOUNCE_TICKS-1: key_held=0; go to SCAN; col_idx+1.
    - Else deb_cnt+1.
- Press-to-event latency: DEBOUNCE_TICKS ticks from the first detecting tick, plus 1 cycle.
- A held key never produces a second key_valid.
- Keys in other columns are invisible while a column is frozen. For simultaneous presses, scan order decides which key wins.
- Reset asserted mid-operation: immediate return to the reset values above, including from HELD and RELEASE.

Test Plan (SCAN_PERIOD=4, DEBOUNCE_TICKS=3):
1. Reset: assert reset=0 then release it, rows=4'b1111 -> cols=1110; key_valid=0; key_held=0; digit_new=0; digit_old=0.
2. Idle: rows=1111 for 20 cycles -> cols steps 1110, 1101, 1011, 0111, 1110, advancing once every 4 cycles; no key_valid.
3. Press '5': drive rows=1101 whenever cols=1101, held for 40 cycles -> exactly one key_valid pulse on the third matching tick +1 cycle; key_code=5; digit_new=5; digit_old=0; key_held=1; cols remains 1101 while held.
4. Release and second key: release '5' (rows=1111 for 3 ticks) -> key_held=0 and scanning resumes at column 2. Then press 'A' (row0, col3) -> digit_new=A; digit_old=5; key_code=A.
5. Bounce: row low for 1 tick, then high -> no key_valid; scan continues from the next column. A release glitch (high 1 tick, then low again) returns to HELD with no new event.
6. Reset in HELD: pull reset low while '5' is held -> cols=1110, key_held=0, digits=0 immediately. After release, '5' still held -> re-detected and one new key_valid, digit_new=5.
